tone_env_pwm: RTL

//  Downstream of the note clock divider. Takes its square-wave div_clk and a note gate.

---
 rtl/synth_pkg.sv | 20 ++
 rtl/adsr_env.sv | 138 +++++++++++++
 rtl/tone_env_pwm.sv | 75 +++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the tone/envelope/PWM voice.
package synth_pkg;

  // Envelope phase, encoded so IDLE is the all-zero reset value.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } env_state_t;

  // Midscale of a pwm_w-bit PWM counter, i.e. the silence duty.
  function automatic int unsigned pwm_half(input int unsigned pwm_w);
    return 32'd1 << (pwm_w - 1);
  endfunction

  localparam int unsigned PWM_HALF = pwm_half(8);

endpackage

// File: rtl/adsr_env.sv
// ADSR envelope generator: tick prescaler, gate synchroniser, phase FSM and level register.
module adsr_env
  import synth_pkg::*;
#(
  parameter int unsigned ENV_W        = 8,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned ATTACK_STEP  = 4,
  parameter int unsigned DECAY_STEP   = 1,
  parameter int unsigned SUSTAIN_LVL  = 160,
  parameter int unsigned RELEASE_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate,
  output logic [ENV_W-1:0] env_level,
  output logic             busy
);

  localparam int unsigned PrescW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned EnvWide = ENV_W + 1;

  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);
  localparam logic [ENV_W:0]    FullLvl  = {1'b0, {ENV_W{1'b1}}};
  localparam logic [ENV_W:0]    AttStep  = EnvWide'(ATTACK_STEP);
  localparam logic [ENV_W:0]    DecStep  = EnvWide'(DECAY_STEP);
  localparam logic [ENV_W:0]    RelStep  = EnvWide'(RELEASE_STEP);
  localparam logic [ENV_W:0]    SusLvl   = EnvWide'(SUSTAIN_LVL);

  logic [PrescW-1:0] presc_q, presc_d;
  logic              env_tick;
  logic              sync1_q, sync2_q, gate_q;
  logic              gate_s, gate_rise;
  env_state_t        state_q, state_d;
  logic [ENV_W-1:0]  env_q, env_d;
  logic [ENV_W:0]    att_sum, dec_diff, rel_diff;

  assign gate_s = sync2_q;
  // IDLE and RELEASE are only ever entered with gate_s low, so a rising edge
  // is exactly "gate_s is high" in those phases.
  assign gate_rise = gate_s & ~gate_q;

  // Free-running envelope tick prescaler.
  always_comb begin
    env_tick = (presc_q == PrescMax);
    presc_d  = env_tick ? '0 : presc_q + 1'b1;
  end

  // Prescaler, gate synchroniser and edge-detect copy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sync1_q <= gate;
      sync2_q <= sync1_q;
      gate_q  <= sync2_q;
    end
  end

  // Envelope phase and level registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      env_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  // Next phase and level; a gate-driven transition pre-empts the tick step.
  always_comb begin
    // One extra bit catches saturation on the way up and underflow on the way down.
    att_sum  = {1'b0, env_q} + AttStep;
    dec_diff = {1'b0, env_q} - DecStep;
    rel_diff = {1'b0, env_q} - RelStep;
    state_d  = state_q;
    env_d    = env_q;
    case (state_q)
      StIdle: begin
        if (gate_rise) state_d = StAttack;
      end
      StAttack: begin
        if (!gate_s) begin
          state_d = StRelease;
        end else if (env_tick) begin
          if (att_sum >= FullLvl) begin
            env_d   = FullLvl[ENV_W-1:0];
            state_d = StDecay;
          end else begin
            env_d = att_sum[ENV_W-1:0];
          end
        end
      end
      StDecay: begin
        if (!gate_s) begin
          state_d = StRelease;
        end else if (env_tick) begin
          if (dec_diff[ENV_W] || (dec_diff <= SusLvl)) begin
            env_d   = SusLvl[ENV_W-1:0];
            state_d = StSustain;
          end else begin
            env_d = dec_diff[ENV_W-1:0];
          end
        end
      end
      StSustain: begin
        if (!gate_s) state_d = StRelease;
      end
      StRelease: begin
        if (gate_rise) begin
          state_d = StAttack;
        end else if (env_tick) begin
          if (rel_diff[ENV_W] || (rel_diff == '0)) begin
            env_d   = '0;
            state_d = StIdle;
          end else begin
            env_d = rel_diff[ENV_W-1:0];
          end
        end
      end
      default: begin
        state_d = StIdle;
        env_d   = '0;
      end
    endcase
  end

  // Status outputs.
  always_comb begin
    busy      = (state_q != StIdle);
    env_level = env_q;
  end

endmodule

// File: rtl/tone_env_pwm.sv
// Tone voice: ADSR envelope scales the note square wave, rendered as single-bit PWM.
module tone_env_pwm
  import synth_pkg::*;
#(
  parameter int unsigned ENV_W        = 8,
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned ATTACK_STEP  = 4,
  parameter int unsigned DECAY_STEP   = 1,
  parameter int unsigned SUSTAIN_LVL  = 160,
  parameter int unsigned RELEASE_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             gate,
  output logic             pwm_out,
  output logic [ENV_W-1:0] env_level,
  output logic             busy
);

  localparam int unsigned      AmpShift = ENV_W - PWM_W + 1;
  localparam logic [PWM_W-1:0] Half     = PWM_W'(pwm_half(PWM_W));

  logic [ENV_W-1:0] env_shifted;
  logic [PWM_W-1:0] amp, next_duty;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             pwm_out_q, pwm_out_d;

  adsr_env #(
    .ENV_W       (ENV_W),
    .TICK_DIV    (TICK_DIV),
    .ATTACK_STEP (ATTACK_STEP),
    .DECAY_STEP  (DECAY_STEP),
    .SUSTAIN_LVL (SUSTAIN_LVL),
    .RELEASE_STEP(RELEASE_STEP)
  ) u_adsr_env (
    .clk      (clk),
    .rst      (rst),
    .gate     (gate),
    .env_level(env_level),
    .busy     (busy)
  );

  // Signed sample around midscale; amp tops out one below HALF so duty never wraps.
  always_comb begin
    env_shifted = env_level >> AmpShift;
    amp         = env_shifted[PWM_W-1:0];
    next_duty   = div_clk ? (Half + amp) : (Half - amp);
  end

  // PWM next state; duty only updates at the period boundary to avoid glitches.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    duty_d    = (pwm_cnt_q == '1) ? next_duty : duty_q;
    pwm_out_d = (pwm_cnt_q < duty_q);
  end

  // PWM counter, latched duty and registered output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm_cnt_q <= '0;
      duty_q    <= Half;
      pwm_out_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule
